// File: rtl/shift_pkg.sv
// Shared constants, FSM state encoding and latched shift-mode layout for the
// multi-bit shift sequencer and its one-bit shifter.
package shift_pkg;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic la;
        logic lr;
    } mode_t;

endpackage

// File: rtl/shifter.sv
// Combinational one-bit shifter: left logical, right logical or right
// arithmetic, with the bit pushed out reported on C.
module shifter
    import shift_pkg::*;
(
    input  logic [WIDTH-1:0] A,
    input  logic             LA,
    input  logic             LR,
    output logic [WIDTH-1:0] Y,
    output logic             C
);

    always_comb begin
        if (LR) begin
            Y = {(LA & A[WIDTH-1]), A[WIDTH-1:1]};
            C = A[0];
        end else begin
            Y = {A[WIDTH-2:0], 1'b0};
            C = A[WIDTH-1];
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-bit shift controller: steps the one-bit shifter once per clock until
// the latched distance is reached, then presents the result with a done pulse.
module shift_sequencer
    import shift_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [AMT_W-1:0] amt,
    input  logic             la,
    input  logic             lr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             c_out,
    output logic             z_out
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    mode_t            mode_q, mode_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             c_q, c_d;
    logic             z_q, z_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] sh_y;
    logic             sh_c;

    shifter u_shifter (
        .A  (acc_q),
        .LA (mode_q.la),
        .LR (mode_q.lr),
        .Y  (sh_y),
        .C  (sh_c)
    );

    // Outputs are registered on the edge that enters DONE, so done, y and
    // z_out all become valid together in the DONE cycle.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        y_d     = y_q;
        c_d     = c_q;
        z_d     = z_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = a_in;
                    cnt_d   = amt;
                    mode_d  = '{la: la, lr: lr};
                    c_d     = 1'b0;
                    busy_d  = 1'b1;
                    if (amt == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        y_d     = a_in;
                        z_d     = (a_in == '0);
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_d = sh_y;
                c_d   = sh_c;
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    y_d     = sh_y;
                    z_d     = (sh_y == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            y_q     <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            y_q     <= y_d;
            c_q     <= c_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign y     = y_q;
    assign c_out = c_q;
    assign z_out = z_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed scenarios plus randomized
// operations compared against a closed-form shift model.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a_in = 8'h00;
    logic [2:0] amt = 3'd0;
    logic       la = 1'b0;
    logic       lr = 1'b0;
    logic       busy, done, c_out, z_out;
    logic [7:0] y;

    int errors = 0;
    int checks = 0;

    shift_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a_in  (a_in),
        .amt   (amt),
        .la    (la),
        .lr    (lr),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .c_out (c_out),
        .z_out (z_out)
    );

    always #5 clk = ~clk;

    // Whole-distance shift computed directly from the operation's definition.
    function automatic void model(input logic [7:0] a, input logic [2:0] n,
                                  input logic la_v, input logic lr_v,
                                  output logic [7:0] ey, output logic ec);
        int d;
        d = int'(n);
        if (d == 0) begin
            ey = a;
            ec = 1'b0;
        end else if (!lr_v) begin
            ey = 8'(a << d);
            ec = a[8-d];
        end else if (!la_v) begin
            ey = a >> d;
            ec = a[d-1];
        end else begin
            ey = 8'($signed(a) >>> d);
            ec = a[d-1];
        end
    endfunction

    // Issues one start, scrambles the inputs afterwards, and watches 12 cycles.
    // restart_at > 0 pulses start (with a_in=FF) during that cycle number.
    task automatic run_op(input logic [7:0] a, input logic [2:0] n,
                          input logic la_v, input logic lr_v, input int restart_at,
                          output int lat, output logic [7:0] yo, output logic co,
                          output logic zo, output int pulses);
        @(negedge clk);
        a_in = a; amt = n; la = la_v; lr = lr_v; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in = 8'($urandom); amt = 3'($urandom); la = 1'($urandom); lr = 1'($urandom);
        lat = -1; pulses = 0; yo = 8'hxx; co = 1'bx; zo = 1'bx;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                pulses++;
                if (lat < 0) begin
                    lat = k; yo = y; co = c_out; zo = z_out;
                end
            end
            if (k == restart_at) begin
                start = 1'b1;
                a_in = 8'hFF;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({y, c_out, busy, done, z_out} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reset: got y=%h c=%b busy=%b done=%b z=%b expected y=00 c=0 busy=0 done=0 z=1",
                     y, c_out, busy, done, z_out);
        end
    endtask

    task automatic test_directed(input string name, input logic [7:0] a, input logic [2:0] n,
                                 input logic la_v, input logic lr_v, input int restart_at,
                                 input int exp_lat, input logic [7:0] exp_y, input logic exp_c);
        int lat, pulses;
        logic [7:0] yo;
        logic co, zo;
        run_op(a, n, la_v, lr_v, restart_at, lat, yo, co, zo, pulses);
        checks++;
        if (lat != exp_lat || pulses != 1) begin
            errors++;
            $display("[TB] FAIL %s latency: got cycle %0d pulses %0d expected cycle %0d pulses 1",
                     name, lat, pulses, exp_lat);
        end
        checks++;
        if ({yo, co, zo} !== {exp_y, exp_c, exp_y == 8'h00}) begin
            errors++;
            $display("[TB] FAIL %s result: got y=%h c=%b z=%b expected y=%h c=%b z=%b",
                     name, yo, co, zo, exp_y, exp_c, exp_y == 8'h00);
        end
        checks++;
        if ({y, c_out, busy} !== {exp_y, exp_c, 1'b0}) begin
            errors++;
            $display("[TB] FAIL %s idle hold: got y=%h c=%b busy=%b expected y=%h c=%b busy=0",
                     name, y, c_out, busy, exp_y, exp_c);
        end
    endtask

    task automatic test_reset_abort();
        int pulses = 0;
        @(negedge clk);
        a_in = 8'hFF; amt = 3'd5; la = 1'b0; lr = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({y, c_out, busy, done, z_out} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL abort reset: got y=%h c=%b busy=%b done=%b z=%b expected 00 0 0 0 1",
                     y, c_out, busy, done, z_out);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy || y != 8'h00) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("[TB] FAIL abort quiet: got %0d active cycles expected 0", pulses);
        end
        test_directed("after_abort", 8'hFF, 3'd5, 1'b0, 1'b0, -1, 6, 8'hE0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int lat = -1;
        logic [7:0] ey;
        logic ec;
        @(negedge clk);
        a_in = 8'h3C; amt = 3'd2; la = 1'b0; lr = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 10 && !done; k++) @(negedge clk);
        a_in = 8'h96; amt = 3'd2; la = 1'b1; lr = 1'b1; start = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, y} !== {1'b0, 1'b0, 8'h0F}) begin
            errors++;
            $display("[TB] FAIL b2b idle gap: got busy=%b done=%b y=%h expected busy=0 done=0 y=0f",
                     busy, done, y);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done && lat < 0) lat = k;
        end
        model(8'h96, 3'd2, 1'b1, 1'b1, ey, ec);
        checks++;
        if (lat != 3 || y !== ey || c_out !== ec) begin
            errors++;
            $display("[TB] FAIL b2b second op: got cycle %0d y=%h c=%b expected cycle 3 y=%h c=%b",
                     lat, y, c_out, ey, ec);
        end
    endtask

    task automatic test_random();
        logic [7:0] a, ey;
        logic [2:0] n;
        logic la_v, lr_v, ec;
        for (int i = 0; i < 40; i++) begin
            a    = (i % 8 == 7) ? 8'h00 : 8'($urandom);
            n    = 3'($urandom_range(0, 7));
            la_v = 1'($urandom);
            lr_v = 1'($urandom);
            model(a, n, la_v, lr_v, ey, ec);
            test_directed("random", a, n, la_v, lr_v, -1, int'(n) + 1, ey, ec);
        end
    endtask

    initial begin
        test_reset();
        test_directed("sra_b4_3", 8'hB4, 3'd3, 1'b1, 1'b1, -1, 4, 8'hF6, 1'b1);
        test_directed("shl_81_1", 8'h81, 3'd1, 1'b1, 1'b0, -1, 2, 8'h02, 1'b1);
        test_directed("amt_zero", 8'h5A, 3'd0, 1'b0, 1'b1, -1, 1, 8'h5A, 1'b0);
        test_directed("busy_start", 8'h80, 3'd7, 1'b0, 1'b1, 3, 8, 8'h01, 1'b0);
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
